// File: rtl/threshold_neuron_if.sv
// Bundle of weight/threshold programming, vector input and result output signals
// for threshold_neuron; the bench drives the master side.
interface threshold_neuron_if #(
   parameter int N_IN  = 4,
   parameter int W_W   = 4,
   parameter int ACC_W = 8
);
   localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

   logic                    w_we;
   logic [AW-1:0]           w_addr;
   logic signed [W_W-1:0]   w_data;
   logic                    thr_we;
   logic signed [ACC_W-1:0] thr_data;
   logic                    in_valid;
   logic                    in_ready;
   logic [N_IN-1:0]         x;
   logic                    out_valid;
   logic                    out_ready;
   logic                    fire;
   logic signed [ACC_W-1:0] sum;

   modport master (
      output w_we, w_addr, w_data, thr_we, thr_data, in_valid, x, out_ready,
      input  in_ready, out_valid, fire, sum
   );

   modport slave (
      input  w_we, w_addr, w_data, thr_we, thr_data, in_valid, x, out_ready,
      output in_ready, out_valid, fire, sum
   );
endinterface

// File: rtl/threshold_neuron.sv
// Serial binary-input threshold neuron: accumulates one gated signed weight per
// cycle with saturation, then compares the sum against a programmable threshold.
module threshold_neuron #(
   parameter int N_IN  = 4,
   parameter int W_W   = 4,
   parameter int ACC_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   threshold_neuron_if.slave   bus,
   output logic [1:0]          dbg_state
);
   localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both 1; valid may not depend on ready, and payload is held while valid waits.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                  state, state_next;
   logic [N_IN-1:0]         x_q;
   logic signed [ACC_W-1:0] acc, acc_next, thr, sum_q;
   logic                    fire_q;
   logic [AW-1:0]           idx;
   logic signed [W_W-1:0]   w [N_IN];
   logic signed [W_W-1:0]   w_sel;
   logic signed [ACC_W:0]   term, wide;
   logic                    last, addr_ok;

   assign last    = (idx == AW'(N_IN - 1));
   assign addr_ok = ({1'b0, bus.w_addr} < (AW+1)'(N_IN));

   // One extra bit of headroom exposes overflow as a mismatch of the top two bits.
   always_comb begin
      w_sel = w[idx];
      term  = x_q[idx] ? {{(ACC_W+1-W_W){w_sel[W_W-1]}}, w_sel} : '0;
      wide  = {acc[ACC_W-1], acc} + term;
      if (wide[ACC_W] != wide[ACC_W-1])
         acc_next = wide[ACC_W] ? ACC_MIN : ACC_MAX;
      else
         acc_next = wide[ACC_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_next = ACCUM;
         ACCUM:   if (last)          state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q    <= '0;
         acc    <= '0;
         idx    <= '0;
         thr    <= '0;
         sum_q  <= '0;
         fire_q <= 1'b0;
         for (int i = 0; i < N_IN; i++) w[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Programming is only legal here so a running sum sees one weight set.
               if (bus.w_we && addr_ok) w[bus.w_addr] <= bus.w_data;
               if (bus.thr_we)          thr <= bus.thr_data;
               if (bus.in_valid) begin
                  x_q <= bus.x;
                  acc <= '0;
                  idx <= '0;
               end
            end
            ACCUM: begin
               acc <= acc_next;
               idx <= idx + 1'b1;
               if (last) begin
                  sum_q  <= acc_next;
                  fire_q <= (acc_next >= thr);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.sum       = sum_q;
   assign bus.fire      = fire_q;
   assign dbg_state     = state;
endmodule

// File: tb/tb_threshold_neuron.sv
// Directed bench for threshold_neuron: an 8-bit-accumulator instance for the main
// behaviour and a 4-bit-accumulator instance for saturation, checked via scoreboards.
module tb_threshold_neuron;
   logic clk;
   logic rst;
   logic [1:0] dbg8, dbg4;

   threshold_neuron_if #(.N_IN(4), .W_W(4), .ACC_W(8)) b8 ();
   threshold_neuron_if #(.N_IN(4), .W_W(4), .ACC_W(4)) b4 ();

   threshold_neuron #(.N_IN(4), .W_W(4), .ACC_W(8)) dut (
      .clk(clk), .rst(rst), .bus(b8.slave), .dbg_state(dbg8)
   );
   threshold_neuron #(.N_IN(4), .W_W(4), .ACC_W(4)) dut4 (
      .clk(clk), .rst(rst), .bus(b4.slave), .dbg_state(dbg4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [8:0] exp_q[$];
   logic [4:0] exp4_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         mw[4];
   int         mw4[4];
   int         mthr = 0;
   int         mthr4 = 0;
   logic [8:0] last_exp;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input int wv[4], input int thr, input logic [3:0] xv,
                                 input int accw, output int s, output bit f);
      int hi, lo;
      hi = (1 << (accw - 1)) - 1;
      lo = -(1 << (accw - 1));
      s = 0;
      for (int i = 0; i < 4; i++) begin
         if (xv[i]) s = s + wv[i];
         if (s > hi) s = hi;
         if (s < lo) s = lo;
      end
      f = (s >= thr);
   endfunction

   function automatic logic [8:0] expect8(input logic [3:0] xv);
      int s;
      bit f;
      model(mw, mthr, xv, 8, s, f);
      return {f, s[7:0]};
   endfunction

   task automatic write_w(input int addr, input int val, input bit apply);
      b8.w_we = 1'b1;
      b8.w_addr = addr[1:0];
      b8.w_data = val[3:0];
      if (apply) mw[addr] = val;
      tick();
      b8.w_we = 1'b0;
   endtask

   task automatic write_thr(input int val);
      b8.thr_we = 1'b1;
      b8.thr_data = val[7:0];
      mthr = val;
      tick();
      b8.thr_we = 1'b0;
   endtask

   task automatic accept(input logic [3:0] xv);
      b8.in_valid = 1'b1;
      b8.x = xv;
      exp_q.push_back(expect8(xv));
      tick();
      b8.in_valid = 1'b0;
      b8.x = ~xv;
   endtask

   task automatic wait_result(input string tag, input int exp_lat);
      int lat;
      logic [8:0] e;
      lat = 0;
      while (!b8.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
      last_exp = e;
      check(tag, {b8.fire, b8.sum}, e);
   endtask

   task automatic release_out(input string tag);
      b8.out_ready = 1'b1;
      tick();
      b8.out_ready = 1'b0;
      check({tag, "_idle_ready"}, b8.in_ready, 1);
      check({tag, "_idle_valid"}, b8.out_valid, 0);
   endtask

   task automatic run(input string tag, input logic [3:0] xv);
      accept(xv);
      wait_result(tag, 4);
      release_out(tag);
   endtask

   task automatic sm_write_all(input int v0, input int v1, input int v2, input int v3);
      int vals[4];
      vals = '{v0, v1, v2, v3};
      for (int i = 0; i < 4; i++) begin
         b4.w_we = 1'b1;
         b4.w_addr = i[1:0];
         b4.w_data = vals[i][3:0];
         mw4[i] = vals[i];
         tick();
      end
      b4.w_we = 1'b0;
   endtask

   task automatic sm_run(input string tag, input logic [3:0] xv);
      int s, lat;
      bit f;
      logic [4:0] e;
      model(mw4, mthr4, xv, 4, s, f);
      exp4_q.push_back({f, s[3:0]});
      b4.in_valid = 1'b1;
      b4.x = xv;
      tick();
      b4.in_valid = 1'b0;
      lat = 0;
      while (!b4.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, 4);
      e = (exp4_q.size() > 0) ? exp4_q.pop_front() : 5'bx;
      check(tag, {b4.fire, b4.sum}, e);
      b4.out_ready = 1'b1;
      tick();
      b4.out_ready = 1'b0;
   endtask

   initial begin
      int k, got, cyc, last_acc;
      logic [3:0] xv;
      logic signed [3:0] tw;
      logic [8:0] e;

      b8.w_we = 0; b8.w_addr = 0; b8.w_data = 0; b8.thr_we = 0; b8.thr_data = 0;
      b8.in_valid = 0; b8.x = 0; b8.out_ready = 0;
      b4.w_we = 0; b4.w_addr = 0; b4.w_data = 0; b4.thr_we = 0; b4.thr_data = 0;
      b4.in_valid = 0; b4.x = 0; b4.out_ready = 0;
      for (int i = 0; i < 4; i++) begin mw[i] = 0; mw4[i] = 0; end

      // Reset state
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      check("rst_in_ready", b8.in_ready, 1);
      check("rst_out_valid", b8.out_valid, 0);
      check("rst_sum_fire", {b8.fire, b8.sum}, 0);
      check("rst_state", dbg8, 0);

      // Basic weighted sums
      write_w(0, 3, 1);
      write_w(1, -2, 1);
      write_w(2, 3, 1);
      write_w(3, -2, 1);
      write_thr(1);
      run("x0001", 4'b0001);
      run("x0011", 4'b0011);
      run("x1010", 4'b1010);

      // Stall in DONE: outputs held, in_valid ignored
      accept(4'b0101);
      wait_result("stall", 4);
      check("stall_state", dbg8, 2);
      for (int i = 0; i < 5; i++) begin
         b8.in_valid = 1'b1;
         b8.x = 4'($urandom_range(0, 15));
         tick();
         b8.in_valid = 1'b0;
         check("stall_valid", b8.out_valid, 1);
         check("stall_ready", b8.in_ready, 0);
         check("stall_hold", {b8.fire, b8.sum}, last_exp);
      end
      release_out("stall");
      repeat (3) tick();
      check("stall_no_spurious", b8.out_valid, 0);

      // Writes during ACCUM are ignored; writes in IDLE take effect
      accept(4'b0010);
      tick();
      tick();
      b8.thr_we = 1'b1;
      b8.thr_data = 8'hF6;
      write_w(1, 7, 0);
      b8.thr_we = 1'b0;
      wait_result("accum_wr", 1);
      release_out("accum_wr");
      run("accum_wr_next", 4'b0010);
      write_w(1, 7, 1);
      run("idle_wr", 4'b0010);

      // Write and accept on the same edge
      b8.w_we = 1'b1;
      b8.w_addr = 2'd1;
      b8.w_data = 4'd5;
      mw[1] = 5;
      accept(4'b0011);
      b8.w_we = 1'b0;
      wait_result("same_edge", 4);
      release_out("same_edge");

      // Random weights, thresholds and vectors
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 4; i++) begin
            tw = 4'($urandom_range(0, 15));
            write_w(i, int'(tw), 1);
         end
         write_thr(int'($urandom_range(0, 20)) - 10);
         run("random", 4'($urandom_range(0, 15)));
      end

      // Reset mid-computation dominates other strobes
      accept(4'b1111);
      tick();
      tick();
      rst = 1'b1;
      b8.in_valid = 1'b1;
      b8.w_we = 1'b1;
      b8.thr_we = 1'b1;
      b8.out_ready = 1'b1;
      tick();
      rst = 1'b0;
      b8.in_valid = 1'b0;
      b8.w_we = 1'b0;
      b8.thr_we = 1'b0;
      b8.out_ready = 1'b0;
      check("midrst_out_valid", b8.out_valid, 0);
      check("midrst_in_ready", b8.in_ready, 1);
      check("midrst_sum_fire", {b8.fire, b8.sum}, 0);
      exp_q.delete();
      for (int i = 0; i < 4; i++) mw[i] = 0;
      mthr = 0;
      run("post_rst", 4'b1111);

      // Back-to-back streaming with in_valid and out_ready held high
      write_w(0, 1, 1);
      write_w(1, 2, 1);
      write_w(2, 4, 1);
      write_w(3, -8, 1);
      write_thr(0);
      k = 0;
      got = 0;
      cyc = 0;
      last_acc = 0;
      b8.in_valid = 1'b1;
      b8.out_ready = 1'b1;
      while (got < 5 && cyc < 200) begin
         if (b8.out_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
            check("stream", {b8.fire, b8.sum}, e);
            got++;
         end
         if (b8.in_ready) begin
            if (k < 5) begin
               xv = 4'($urandom_range(0, 15));
               b8.x = xv;
               exp_q.push_back(expect8(xv));
               if (k > 0) check("stream_period", cyc - last_acc, 6);
               last_acc = cyc;
               k++;
            end else begin
               b8.in_valid = 1'b0;
            end
         end else begin
            b8.x = 4'($urandom_range(0, 15));
         end
         tick();
         cyc++;
      end
      b8.in_valid = 1'b0;
      b8.out_ready = 1'b0;
      check("stream_count", got, 5);
      check("stream_leftover", exp_q.size(), 0);

      // Saturation with a 4-bit accumulator
      sm_write_all(7, 7, 7, 7);
      sm_run("sat_pos", 4'b1111);
      sm_write_all(-8, -8, -8, -8);
      sm_run("sat_neg", 4'b1111);
      sm_write_all(7, 7, -8, 0);
      sm_run("sat_step", 4'b0111);
      sm_run("sat_two", 4'b0011);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/threshold_neuron.md
THRESHOLD_NEURON -- requirements
Module: threshold_neuron

Interface
REQ-001 Parameter N_IN, default 4: number of binary inputs (>=2).
REQ-002 Parameter W_W, default 4: signed weight width (two's complement).
REQ-003 Parameter ACC_W, default 8: signed accumulator, threshold and sum width (>=W_W).
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 w_we  in  1  weight write strobe.
REQ-007 w_addr  in  $clog2(N_IN)  weight index.
REQ-008 w_data  in  W_W  signed weight value.
REQ-009 thr_we  in  1  threshold write strobe.
REQ-010 thr_data  in  ACC_W  signed threshold value.
REQ-011 in_valid  in  1  input vector x offered.
REQ-012 in_ready  out  1  block can accept x.
REQ-013 x  in  N_IN  binary input vector; bit i gates weight i.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  consumer accepts result.
REQ-016 fire  out  1  1 when sum >= threshold (signed compare).
REQ-017 sum  out  ACC_W  saturated signed weighted sum.

Function
REQ-018 States: IDLE, ACCUM, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-019 IDLE, in_valid=1: on that edge latch x, clear acc, idx=0, go ACCUM.
REQ-020 ACCUM: each edge acc <= sat(acc + (x[idx] ? sext(w[idx]) : 0)), idx++; edge with idx==N_IN-1 goes DONE.
REQ-021 Latency: out_valid is high exactly N_IN cycles after the accept edge.
REQ-022 Saturation: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] at every step; no wrap-around.
REQ-023 Entering DONE, sum and fire registered from final acc and current threshold; both held stable while out_valid=1.
REQ-024 DONE, out_ready=1: go IDLE on that edge; out_ready=0 holds DONE indefinitely.
REQ-025 Minimum accept-to-accept period N_IN+2 cycles; IDLE lasts >=1 cycle between results.
REQ-026 Weight/threshold writes take effect only in IDLE; ignored in ACCUM and DONE.
REQ-027 Write and accept on the same IDLE edge: write applies, new value used by that computation.
REQ-028 w_addr >= N_IN (non-power-of-2 N_IN): write ignored.
REQ-029 in_valid outside IDLE ignored; x not re-sampled after accept.
REQ-030 Outside DONE, sum and fire hold last registered values.

Reset
REQ-031 rst=1 at an edge, from any state: state IDLE, acc=0, idx=0, all weights 0, threshold 0, sum=0, fire=0, out_valid=0.
REQ-032 Reset dominates simultaneous in_valid, w_we, thr_we and out_ready; in_ready=1 in first cycle after rst deasserts.

Verification (N_IN=4, W_W=4, ACC_W=8 unless stated)
REQ-033 Weights {w0..w3}={3,-2,3,-2}, thr=1; x=4'b0001 -> sum=3 fire=1; x=4'b0011 -> sum=1 fire=1; x=4'b1010 -> sum=-4 fire=0; each out_valid 4 cycles after accept.
REQ-034 ACC_W=4, weights all 7, x=4'b1111 -> sum=7 (saturated); weights all -8 -> sum=-8; thr=0 gives fire=1 then fire=0.
REQ-035 out_ready=0 for 5 cycles in DONE -> out_valid, sum, fire stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-036 w_we to w1 with value 7 during ACCUM -> current and next results use old w1; same write in IDLE -> next result uses 7.
REQ-037 rst pulsed 2 cycles after accept -> next cycle out_valid=0, in_ready=1; x=4'b1111 then gives sum=0 fire=1 (zero weights, thr 0).
REQ-038 in_valid and out_ready held 1 -> accepts every 6 cycles, no vector dropped or duplicated.
